branch_predict_unit: RTL and testbench

Branch resolution and prediction unit for the RV32 core, generalising the single BEQ compare path. It resolves all six RV32I conditional branches and keeps a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. Fetch queries it each cycle for a predicted next PC, and execute feeds back resolved branches to train it and raise mispredict redirects. The datapath is XLEN-parametrised and the table depth is configurable.

---
 rtl/rv32_pkg.sv | 39 +++
 rtl/branch_cmp.sv | 29 ++
 rtl/branch_predict_unit.sv | 102 ++++++++++
 tb/tb_branch_predict_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: branch funct3 codes, 2-bit predictor counter
// encodings, the BTB entry layout and the counter saturation helper.
package rv32_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Canonical RV32 / 16-entry layout; parametrised users build the same
    // field order with their own widths.
    localparam int BTB_XLEN  = 32;
    localparam int BTB_IDX_W = 4;
    localparam int BTB_TAG_W = BTB_XLEN - 2 - BTB_IDX_W;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_XLEN-1:0]  target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_update(input ctr_t c, input logic taken);
        if (taken)
            return (c == ST) ? ST : ctr_t'(c + 2'd1);
        else
            return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// RV32I conditional-branch comparator; also used by the single-cycle datapath.
// Illegal funct3 values (010, 011) report legal=0 and taken=0.
module branch_cmp
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b1;
        case (funct3)
            BR_BEQ:  taken = (rs1 == rs2);
            BR_BNE:  taken = (rs1 != rs2);
            BR_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            BR_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            BR_BLTU: taken = (rs1 <  rs2);
            BR_BGEU: taken = (rs1 >= rs2);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus a direct-mapped BTB of 2-bit saturating counters.
// Lookup and resolution are combinational; table and counters update on clk.
module branch_predict_unit
    import rv32_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] res_rs1,
    input  logic [XLEN-1:0] res_rs2,
    input  logic [XLEN-1:0] res_imm,
    input  logic [2:0]      res_funct3,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_pred_target,
    output logic            res_taken,
    output logic [XLEN-1:0] res_next_pc,
    output logic            res_mispredict,
    output logic [XLEN-1:0] cnt_branches,
    output logic [XLEN-1:0] cnt_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        ctr_t             ctr;
    } entry_t;

    entry_t btb [ENTRIES];

    logic [IDX_W-1:0] look_idx, res_idx;
    logic [TAG_W-1:0] look_tag, res_tag;
    entry_t           look_e, res_e;
    logic             look_hit, res_hit;
    logic             legal, cmp_taken;
    logic [XLEN-1:0]  target;

    assign look_idx = pred_pc[IDX_W+1:2];
    assign look_tag = pred_pc[XLEN-1:IDX_W+2];
    assign res_idx  = res_pc[IDX_W+1:2];
    assign res_tag  = res_pc[XLEN-1:IDX_W+2];

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign look_e      = btb[look_idx];
    assign look_hit    = look_e.valid && (look_e.tag == look_tag);
    assign pred_taken  = look_hit && look_e.ctr[1];
    assign pred_target = pred_taken ? look_e.target : pred_pc + XLEN'(4);

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .rs1    (res_rs1),
        .rs2    (res_rs2),
        .funct3 (res_funct3),
        .taken  (cmp_taken),
        .legal  (legal)
    );

    assign res_e       = btb[res_idx];
    assign res_hit     = res_e.valid && (res_e.tag == res_tag);
    assign target      = res_pc + res_imm;
    assign res_taken   = cmp_taken;
    assign res_next_pc = cmp_taken ? target : res_pc + XLEN'(4);

    // No handshake: res_valid qualifies exactly one resolve in the current cycle.
    assign res_mispredict = res_valid && legal &&
                            ((cmp_taken != res_pred_taken) ||
                             (cmp_taken && (res_pred_target != target)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
            cnt_branches    <= '0;
            cnt_mispredicts <= '0;
        end else if (res_valid && legal) begin
            cnt_branches <= cnt_branches + XLEN'(1);
            if (res_mispredict) begin
                cnt_mispredicts <= cnt_mispredicts + XLEN'(1);
            end
            if (res_hit) begin
                btb[res_idx].ctr <= ctr_update(res_e.ctr, cmp_taken);
                if (cmp_taken) begin
                    btb[res_idx].target <= target;
                end
            end else if (cmp_taken) begin
                // A taken miss evicts whatever alias occupied this index.
                btb[res_idx] <= '{valid: 1'b1, tag: res_tag, target: target, ctr: WT};
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: resolution, training, saturation,
// aliasing, same-cycle lookup/update, address wrap and asynchronous reset.
module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        res_valid;
    logic [31:0] res_pc, res_rs1, res_rs2, res_imm;
    logic [2:0]  res_funct3;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        res_taken;
    logic [31:0] res_next_pc;
    logic        res_mispredict;
    logic [31:0] cnt_branches, cnt_mispredicts;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_br = 0;
    logic [31:0] exp_mp = 0;

    branch_predict_unit #(.XLEN(32), .ENTRIES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .pred_pc         (pred_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .res_valid       (res_valid),
        .res_pc          (res_pc),
        .res_rs1         (res_rs1),
        .res_rs2         (res_rs2),
        .res_imm         (res_imm),
        .res_funct3      (res_funct3),
        .res_pred_taken  (res_pred_taken),
        .res_pred_target (res_pred_target),
        .res_taken       (res_taken),
        .res_next_pc     (res_next_pc),
        .res_mispredict  (res_mispredict),
        .cnt_branches    (cnt_branches),
        .cnt_mispredicts (cnt_mispredicts)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic v, input logic [31:0] pc, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] imm, input logic [2:0] f3,
                             input logic pt, input logic [31:0] ptgt);
        res_valid       = v;
        res_pc          = pc;
        res_rs1         = rs1;
        res_rs2         = rs2;
        res_imm         = imm;
        res_funct3      = f3;
        res_pred_taken  = pt;
        res_pred_target = ptgt;
        #1;
    endtask

    task automatic idle();
        res_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pred_pc = 32'h100;
        drive_res(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h0);
        #2;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target: got %h want 00000104", pred_target); end
        n_checks++; if (cnt_branches !== 32'h0) begin n_fail++; $display("FAIL reset_cnt_br: got %0d want 0", cnt_branches); end
        n_checks++; if (cnt_mispredicts !== 32'h0) begin n_fail++; $display("FAIL reset_cnt_mp: got %0d want 0", cnt_mispredicts); end
        n_checks++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict_idle: got %b want 0", res_mispredict); end
        tick();
        tick();
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_beq_taken();
        pred_pc = 32'h4;
        drive_res(1'b1, 32'h4, 32'h0, 32'h0, 32'hFFFF_FFFC, 3'b000, 1'b0, 32'h8);
        n_checks++; if (res_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b want 1", res_taken); end
        n_checks++; if (res_next_pc !== 32'h0) begin n_fail++; $display("FAIL beq_next_pc: got %h want 00000000", res_next_pc); end
        n_checks++; if (res_mispredict !== 1'b1) begin n_fail++; $display("FAIL beq_mispredict: got %b want 1", res_mispredict); end
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL beq_pre_lookup: got %b want 0", pred_taken); end
        exp_br++; exp_mp++;
        tick();
        idle();
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL beq_trained_taken: got %b want 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL beq_trained_target: got %h want 00000000", pred_target); end
        n_checks++; if (cnt_branches !== exp_br) begin n_fail++; $display("FAIL beq_cnt_br: got %0d want %0d", cnt_branches, exp_br); end
        n_checks++; if (cnt_mispredicts !== exp_mp) begin n_fail++; $display("FAIL beq_cnt_mp: got %0d want %0d", cnt_mispredicts, exp_mp); end
    endtask

    task automatic test_beq_not_taken();
        pred_pc = 32'h8;
        drive_res(1'b1, 32'h8, 32'h1, 32'h0, 32'hFFFF_FFFC, 3'b000, 1'b0, 32'hC);
        n_checks++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL bnt_taken: got %b want 0", res_taken); end
        n_checks++; if (res_next_pc !== 32'hC) begin n_fail++; $display("FAIL bnt_next_pc: got %h want 0000000c", res_next_pc); end
        n_checks++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL bnt_mispredict: got %b want 0", res_mispredict); end
        exp_br++;
        tick();
        idle();
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL bnt_no_alloc: got %b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'hC) begin n_fail++; $display("FAIL bnt_target: got %h want 0000000c", pred_target); end
        n_checks++; if (cnt_branches !== exp_br) begin n_fail++; $display("FAIL bnt_cnt_br: got %0d want %0d", cnt_branches, exp_br); end
    endtask

    task automatic test_signed_unsigned();
        logic [2:0] f3_tab  [8];
        logic       exp_tab [8];
        f3_tab  = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b010, 3'b011};
        exp_tab = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
        for (int i = 0; i < 8; i++) begin
            drive_res(1'b0, 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h10, f3_tab[i], ~exp_tab[i], 32'h0);
            n_checks++; if (res_taken !== exp_tab[i]) begin n_fail++; $display("FAIL cmp_f3_%b: got %b want %b", f3_tab[i], res_taken, exp_tab[i]); end
            n_checks++; if (res_next_pc !== (exp_tab[i] ? 32'h210 : 32'h204)) begin n_fail++; $display("FAIL cmp_next_f3_%b: got %h want %h", f3_tab[i], res_next_pc, exp_tab[i] ? 32'h210 : 32'h204); end
            n_checks++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL cmp_idle_mp_f3_%b: got %b want 0", f3_tab[i], res_mispredict); end
        end
        pred_pc = 32'h200;
        drive_res(1'b1, 32'h200, 32'h5, 32'h5, 32'h10, 3'b010, 1'b1, 32'h210);
        n_checks++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL illegal_mispredict: got %b want 0", res_mispredict); end
        tick();
        idle();
        n_checks++; if (cnt_branches !== exp_br) begin n_fail++; $display("FAIL illegal_cnt_br: got %0d want %0d", cnt_branches, exp_br); end
        n_checks++; if (pred_target !== 32'h204) begin n_fail++; $display("FAIL illegal_no_alloc: got %h want 00000204", pred_target); end
    endtask

    task automatic test_saturation();
        pred_pc = 32'h10;
        // T: allocate at WT
        drive_res(1'b1, 32'h10, 32'h3, 32'h3, 32'h20, 3'b000, 1'b0, 32'h14);
        n_checks++; if (res_mispredict !== 1'b1) begin n_fail++; $display("FAIL sat_t1_mp: got %b want 1", res_mispredict); end
        exp_br++; exp_mp++;
        tick();
        idle();
        n_checks++; if (pred_target !== 32'h30) begin n_fail++; $display("FAIL sat_t1_target: got %h want 00000030", pred_target); end
        // T with matching prediction: ST
        drive_res(1'b1, 32'h10, 32'h3, 32'h3, 32'h20, 3'b000, 1'b1, 32'h30);
        n_checks++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL sat_t2_mp: got %b want 0", res_mispredict); end
        exp_br++;
        tick();
        // T with wrong predicted target: stays ST, mispredict on target
        drive_res(1'b1, 32'h10, 32'h3, 32'h3, 32'h20, 3'b000, 1'b1, 32'h34);
        n_checks++; if (res_mispredict !== 1'b1) begin n_fail++; $display("FAIL sat_t3_target_mp: got %b want 1", res_mispredict); end
        exp_br++; exp_mp++;
        tick();
        // N: ST -> WT, still predicted taken
        drive_res(1'b1, 32'h10, 32'h3, 32'h4, 32'h20, 3'b000, 1'b1, 32'h30);
        exp_br++; exp_mp++;
        tick();
        idle();
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_n1_taken: got %b want 1", pred_taken); end
        // N: WT -> WNT, predicted not taken
        drive_res(1'b1, 32'h10, 32'h3, 32'h4, 32'h20, 3'b000, 1'b1, 32'h30);
        exp_br++; exp_mp++;
        tick();
        idle();
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat_n2_taken: got %b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h14) begin n_fail++; $display("FAIL sat_n2_target: got %h want 00000014", pred_target); end
        n_checks++; if (cnt_branches !== exp_br) begin n_fail++; $display("FAIL sat_cnt_br: got %0d want %0d", cnt_branches, exp_br); end
        n_checks++; if (cnt_mispredicts !== exp_mp) begin n_fail++; $display("FAIL sat_cnt_mp: got %0d want %0d", cnt_mispredicts, exp_mp); end
    endtask

    task automatic test_alias();
        drive_res(1'b1, 32'h44, 32'h0, 32'h0, 32'h100, 3'b000, 1'b0, 32'h48);
        exp_br++; exp_mp++;
        tick();
        idle();
        pred_pc = 32'h4;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_evicted_taken: got %b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h8) begin n_fail++; $display("FAIL alias_evicted_target: got %h want 00000008", pred_target); end
        pred_pc = 32'h44;
        #1;
        n_checks++; if (pred_target !== 32'h144) begin n_fail++; $display("FAIL alias_new_target: got %h want 00000144", pred_target); end
    endtask

    task automatic test_back_to_back();
        // Resolve 0x44 not taken while fetch looks up 0x44 in the same cycle.
        pred_pc = 32'h44;
        drive_res(1'b1, 32'h44, 32'h0, 32'h1, 32'h100, 3'b000, 1'b1, 32'h144);
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL same_cycle_old_taken: got %b want 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h144) begin n_fail++; $display("FAIL same_cycle_old_target: got %h want 00000144", pred_target); end
        n_checks++; if (res_mispredict !== 1'b1) begin n_fail++; $display("FAIL same_cycle_mp: got %b want 1", res_mispredict); end
        exp_br++; exp_mp++;
        tick();
        idle();
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_new_taken: got %b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h48) begin n_fail++; $display("FAIL same_cycle_new_target: got %h want 00000048", pred_target); end
    endtask

    task automatic test_wrap();
        drive_res(1'b0, 32'hFFFF_FFFC, 32'h7, 32'h7, 32'h8, 3'b000, 1'b0, 32'h0);
        n_checks++; if (res_next_pc !== 32'h4) begin n_fail++; $display("FAIL wrap_taken_next: got %h want 00000004", res_next_pc); end
        drive_res(1'b0, 32'hFFFF_FFFC, 32'h7, 32'h7, 32'h8, 3'b001, 1'b0, 32'h0);
        n_checks++; if (res_next_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_fallthrough_next: got %h want 00000000", res_next_pc); end
        pred_pc = 32'hFFFF_FFFC;
        #1;
        n_checks++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL wrap_pred_target: got %h want 00000000", pred_target); end
    endtask

    task automatic test_async_reset();
        pred_pc = 32'h80;
        drive_res(1'b1, 32'h80, 32'h1, 32'h2, 32'h40, 3'b100, 1'b0, 32'h84);
        exp_br++; exp_mp++;
        tick();
        idle();
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL pre_reset_taken: got %b want 1", pred_taken); end
        n_checks++; if (cnt_branches !== exp_br) begin n_fail++; $display("FAIL pre_reset_cnt_br: got %0d want %0d", cnt_branches, exp_br); end
        n_checks++; if (cnt_mispredicts !== exp_mp) begin n_fail++; $display("FAIL pre_reset_cnt_mp: got %0d want %0d", cnt_mispredicts, exp_mp); end
        rst = 1'b1;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_reset_taken: got %b want 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h84) begin n_fail++; $display("FAIL async_reset_target: got %h want 00000084", pred_target); end
        n_checks++; if (cnt_branches !== 32'h0) begin n_fail++; $display("FAIL async_reset_cnt_br: got %0d want 0", cnt_branches); end
        n_checks++; if (cnt_mispredicts !== 32'h0) begin n_fail++; $display("FAIL async_reset_cnt_mp: got %0d want 0", cnt_mispredicts); end
        rst = 1'b0;
        tick();
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL post_reset_taken: got %b want 0", pred_taken); end
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_beq_not_taken();
        test_signed_unsigned();
        test_saturation();
        test_alias();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
